mem_port_arbiter: RTL and testbench

Arbitrates the pipelined RISC-V core's single unified memory port between instruction fetch (IF stage) and data access (MEM stage). Grants one outstanding transaction at a time, drives the memory handshake, returns read data to the owning requester and produces per-stage stall signals for the pipeline control. Data accesses have priority; an optional starvation guard bounds how long fetch can be held off.

---
 rtl/riscv_arb_pkg.sv | 28 ++
 rtl/arb_starve_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_arb_pkg.sv
// ============================================================================
// Module   : riscv_arb_pkg
// Brief    : Shared types and default widths for the unified memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_arb_pkg;

    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_DM = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

endpackage

`default_nettype wire

// File: rtl/arb_starve_ctr.sv
// ============================================================================
// Module   : arb_starve_ctr
// Brief    : Saturating count of data grants issued while fetch waits; flags limit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_starve_ctr #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int unsigned c_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign at_limit = (r_cnt == c_LIMIT);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between fetch and data, data-priority,
//            one outstanding transaction. Optional fetch starvation guard
//            enabled by defining ARB_STARVE_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t        r_state;
    arb_owner_t        r_owner;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;

    logic w_idle;
    logic w_starve;
    logic w_pick_if;
    logic w_pick_dm;

    assign w_idle    = (r_state == ST_IDLE);
    assign w_pick_if = w_idle & if_req & (~dm_req | w_starve);
    assign w_pick_dm = w_idle & dm_req & ~w_pick_if;

`ifdef ARB_STARVE_GUARD_EN
    // A fetch grant or an idle cycle without fetch demand ends the streak.
    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk      (clk),
        .reset    (reset),
        .inc      (w_pick_dm & if_req),
        .clr      (w_pick_if | (w_idle & ~if_req)),
        .at_limit (w_starve)
    );
`else
    // Strict data priority; the limit only has meaning with the guard built in.
    assign w_starve = 1'b0 & (STARVE_LIMIT == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_IF;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_dm) begin
                        r_state     <= ST_BUSY_DM;
                        r_owner     <= OWN_DM;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                    end else if (w_pick_if) begin
                        r_state     <= ST_BUSY_IF;
                        r_owner     <= OWN_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end
                end
                ST_BUSY_IF, ST_BUSY_DM: begin
                    if (mem_ready) begin
                        r_state   <= ST_RESP;
                        r_mem_req <= 1'b0;
                        r_rdata   <= r_mem_we ? '0 : mem_rdata;
                        if (r_owner == OWN_IF) begin
                            r_if_rvalid <= 1'b1;
                        end else begin
                            r_dm_rvalid <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign if_gnt    = w_pick_if;
    assign dm_gnt    = w_pick_dm;
    assign if_rvalid = r_if_rvalid;
    assign dm_rvalid = r_dm_rvalid;
    assign if_rdata  = r_if_rvalid ? r_rdata : '0;
    assign dm_rdata  = r_dm_rvalid ? r_rdata : '0;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign stall_if  = if_req & ~r_if_rvalid;
    assign stall_mem = dm_req & ~r_dm_rvalid;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter; the expected
//            grant pattern follows ARB_STARVE_GUARD_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W       = 32;
    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              stall_if;
    logic              stall_mem;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [9:0] gnt_seq;
    logic [9:0] exp_seq;
    int         n_gnt;
    int         n_bad;
    int         n_stray;

    initial begin
        reset     = 1'b1;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;

        #12;
        check_eq("rst_mem_req",   {31'd0, mem_req},   32'd0);
        check_eq("rst_gnts",      {30'd0, if_gnt, dm_gnt}, 32'd0);
        check_eq("rst_rvalids",   {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        check_eq("rst_mem_addr",  mem_addr,  32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        #3 reset = 1'b0;
        next_cycle();

        // Single fetch, memory ready in the first busy cycle
        if_req  = 1'b1;
        if_addr = 32'h0;
        mid();
        check_eq("t1_if_gnt",   {31'd0, if_gnt},   32'd1);
        check_eq("t1_dm_gnt",   {31'd0, dm_gnt},   32'd0);
        check_eq("t1_mem_req0", {31'd0, mem_req},  32'd0);
        check_eq("t1_stall_if", {31'd0, stall_if}, 32'd1);
        next_cycle();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h0050_0093;
        mid();
        check_eq("t1_mem_req1", {31'd0, mem_req}, 32'd1);
        check_eq("t1_mem_addr", mem_addr, 32'h0);
        check_eq("t1_mem_we",   {31'd0, mem_we},  32'd0);
        check_eq("t1_no_gnt",   {31'd0, if_gnt},  32'd0);
        next_cycle();
        mem_ready = 1'b0;
        mem_rdata = '0;
        mid();
        check_eq("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check_eq("t1_if_rdata",  if_rdata, 32'h0050_0093);
        check_eq("t1_mem_req2",  {31'd0, mem_req},   32'd0);
        next_cycle();
        mid();
        check_eq("t1_rvalid_end", {31'd0, if_rvalid}, 32'd0);
        check_eq("t1_stall_end",  {31'd0, stall_if},  32'd0);
        next_cycle();

        // Simultaneous requests: data first, fetch after the response cycle
        if_req  = 1'b1;
        if_addr = 32'h4;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h40;
        mid();
        check_eq("t2_dm_gnt",  {31'd0, dm_gnt},   32'd1);
        check_eq("t2_if_gnt",  {31'd0, if_gnt},   32'd0);
        check_eq("t2_stall_m", {31'd0, stall_mem}, 32'd1);
        next_cycle();
        dm_req    = 1'b0;
        dm_addr   = 32'hFFFF_0000;
        mem_ready = 1'b1;
        mem_rdata = 32'h1111_2222;
        mid();
        check_eq("t2_mem_addr", mem_addr, 32'h40);
        check_eq("t2_if_wait",  {30'd0, if_gnt, stall_if}, 32'd1);
        next_cycle();
        mem_ready = 1'b0;
        mid();
        check_eq("t2_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
        check_eq("t2_dm_rdata",  dm_rdata, 32'h1111_2222);
        check_eq("t2_resp_nogt", {30'd0, if_gnt, if_rvalid}, 32'd0);
        check_eq("t2_stall_if",  {31'd0, stall_if}, 32'd1);
        next_cycle();
        mid();
        check_eq("t2_if_gnt2", {30'd0, if_gnt, dm_gnt}, 32'd2);
        next_cycle();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h00A0_0113;
        mid();
        check_eq("t2_if_addr", mem_addr, 32'h4);
        next_cycle();
        mem_ready = 1'b0;
        mid();
        check_eq("t2_if_rdata", if_rdata, 32'h00A0_0113);
        next_cycle();

        // Data write with three wait cycles; fields must hold steady
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h44;
        dm_wdata = 32'hDEAD_BEEF;
        mid();
        check_eq("t3_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        next_cycle();
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 32'h123;
        dm_wdata = 32'h0;
        for (int w = 0; w < 4; w++) begin
            if (w == 3) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hFFFF_FFFF;
            end
            mid();
            check_eq("t3_busy_ctl",  {29'd0, mem_req, mem_we, dm_rvalid}, 32'd6);
            check_eq("t3_busy_addr", mem_addr,  32'h44);
            check_eq("t3_busy_data", mem_wdata, 32'hDEAD_BEEF);
            next_cycle();
        end
        mem_ready = 1'b0;
        mem_rdata = '0;
        mid();
        check_eq("t3_wr_rvalid", {30'd0, dm_rvalid, mem_req}, 32'd2);
        check_eq("t3_wr_rdata",  dm_rdata, 32'h0);
        next_cycle();

        // Both requesters held continuously for ten transactions
        dm_req    = 1'b1;
        dm_we     = 1'b0;
        dm_addr   = 32'h100;
        if_req    = 1'b1;
        if_addr   = 32'h200;
        mem_ready = 1'b1;
        mem_rdata = 32'h5;
        gnt_seq   = '0;
        n_gnt     = 0;
        n_bad     = 0;
        for (int c = 0; c < 30; c++) begin
            mid();
            if (if_gnt && dm_gnt) n_bad++;
            if ((if_gnt && if_rvalid) || (dm_gnt && dm_rvalid)) n_bad++;
            if (if_gnt || dm_gnt) begin
                if (n_gnt < 10) gnt_seq[n_gnt] = if_gnt;
                n_gnt++;
            end
            next_cycle();
        end
        dm_req = 1'b0;
        if_req = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        exp_seq = 10'b10_0001_0000;
`else
        exp_seq = 10'b00_0000_0000;
`endif
        check_eq("t4_n_gnt",    n_gnt, 32'd10);
        check_eq("t4_gnt_seq",  {22'd0, gnt_seq}, {22'd0, exp_seq});
        check_eq("t4_gnt_rule", n_bad, 32'd0);
        for (int c = 0; c < 4; c++) next_cycle();
        mem_ready = 1'b0;

        // Reset while a data read is in flight
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 32'h80;
        mid();
        check_eq("t5_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        next_cycle();
        dm_req = 1'b0;
        mid();
        check_eq("t5_busy", {31'd0, mem_req}, 32'd1);
        next_cycle();
        mem_ready = 1'b1;
        reset     = 1'b1;
        #1;
        check_eq("t5_rst_drop", {29'd0, mem_req, dm_rvalid, dm_gnt}, 32'd0);
        mid();
        #1 reset = 1'b0;
        n_stray = 0;
        for (int c = 0; c < 3; c++) begin
            mid();
            if (dm_rvalid || mem_req || dm_gnt) n_stray++;
            next_cycle();
        end
        check_eq("t5_abandoned", n_stray, 32'd0);
        mem_ready = 1'b0;
        if_req    = 1'b1;
        if_addr   = 32'h8;
        mid();
        check_eq("t5_new_gnt", {31'd0, if_gnt}, 32'd1);
        next_cycle();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFE_0001;
        mid();
        check_eq("t5_new_addr", mem_addr, 32'h8);
        next_cycle();
        mem_ready = 1'b0;
        mid();
        check_eq("t5_new_rdata", {if_rvalid ? if_rdata : 32'h0}, 32'hCAFE_0001);
        next_cycle();

        // Fetch request withdrawn before it could be granted
        dm_req  = 1'b1;
        dm_addr = 32'h90;
        mid();
        check_eq("t6_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        next_cycle();
        dm_req  = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'hC;
        n_stray = 0;
        mid();
        if (if_gnt || if_rvalid) n_stray++;
        next_cycle();
        if_req    = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        mid();
        if (if_gnt || if_rvalid) n_stray++;
        next_cycle();
        mem_ready = 1'b0;
        mid();
        check_eq("t6_dm_rdata", {dm_rvalid ? dm_rdata : 32'h0}, 32'h77);
        for (int c = 0; c < 3; c++) begin
            if (if_gnt || if_rvalid) n_stray++;
            next_cycle();
            mid();
        end
        check_eq("t6_no_if_txn", n_stray, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
